// File: rtl/uart_pkg.sv
// Shared UART types and constants used by the transmitter and the baud counter.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_tx_state_e;

  typedef enum logic [1:0] {
    PAR_NONE  = 2'd0,
    PAR_EVEN  = 2'd1,
    PAR_ODD   = 2'd2,
    PAR_NONE2 = 2'd3
  } uart_parity_e;

  localparam logic UART_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the wrap cycle.
// A synchronous restart pins the count to 0 so a new bit period can be
// aligned to an arbitrary edge.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 434,
  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             restart_i,
  output logic             tick_o,
  output logic [CNT_W-1:0] count_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  // Next count: restart wins, otherwise wrap at the last clock of the period.
  always_comb begin
    cnt_d = cnt_q;
    if (restart_i) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (cnt_q == CNT_MAX) begin
      cnt_d = {CNT_W{1'b0}};
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
    tick_d = (cnt_d == CNT_MAX);
  end

  // Count and tick registers; tick is high exactly while the count sits at its maximum.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt_q  <= {CNT_W{1'b0}};
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick_o  = tick_q;
  assign count_o = cnt_q;

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: one-entry holding register in front of a frame FSM that
// emits start, 5..9 data bits LSB first, optional parity and 1..2 stop bits.
// tx, busy and frame_done are registered from next-state values so they
// line up with the state they describe.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_BITS-1:0] in_data,
  input  logic [1:0]           parity_mode,
  output logic                 tx,
  output logic                 busy,
  output logic                 frame_done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W = $clog2(DATA_BITS + 1);

  if (CLKS_PER_BIT < 2) begin : g_bad_clks
    $error("uart_tx_frame: CLKS_PER_BIT must be >= 2");
  end
  if ((DATA_BITS < 5) || (DATA_BITS > 9)) begin : g_bad_data
    $error("uart_tx_frame: DATA_BITS must be in 5..9");
  end
  if ((STOP_BITS < 1) || (STOP_BITS > 2)) begin : g_bad_stop
    $error("uart_tx_frame: STOP_BITS must be in 1..2");
  end

  // Parity bit for a payload: even -> XOR of data, odd -> XNOR of data.
  function automatic logic parity_bit(input logic [DATA_BITS-1:0] d, input uart_parity_e m);
    logic p;
    case (m)
      PAR_EVEN: p = ^d;
      PAR_ODD:  p = ~^d;
      default:  p = 1'b0;
    endcase
    return p;
  endfunction

  // Parity is enabled only for the even and odd codes.
  function automatic logic parity_on(input uart_parity_e m);
    logic e;
    case (m)
      PAR_EVEN: e = 1'b1;
      PAR_ODD:  e = 1'b1;
      default:  e = 1'b0;
    endcase
    return e;
  endfunction

  uart_tx_state_e       state_q, state_d;
  logic [DATA_BITS-1:0] hold_data_q, hold_data_d;
  uart_parity_e         hold_par_q, hold_par_d;
  logic                 hold_valid_q, hold_valid_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_en_q, par_en_d;
  logic                 par_bit_q, par_bit_d;
  logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic                 accept_s;
  logic                 load_hold_s;
  logic                 load_in_s;
  logic                 restart_s;
  logic                 tick_s;
  logic [CNT_W-1:0]     cnt_s;
  logic [DATA_BITS-1:0] shifted_s;
  logic                 last_stop_s;

  assign in_ready = ~hold_valid_q;
  assign accept_s = in_valid & ~hold_valid_q;

  // The counter is held at 0 while idle and realigned whenever a frame starts.
  assign restart_s = (state_q == IDLE) | load_hold_s | load_in_s;

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk      (clk),
    .n_rst    (n_rst),
    .restart_i(restart_s),
    .tick_o   (tick_s),
    .count_o  (cnt_s)
  );

  assign last_stop_s = (stop_cnt_q == 1'(STOP_BITS - 1));

  // FSM next state, frame loading, holding register and registered-output values.
  always_comb begin
    state_d      = state_q;
    hold_data_d  = hold_data_q;
    hold_par_d   = hold_par_q;
    hold_valid_d = hold_valid_q;
    shift_d      = shift_q;
    par_en_d     = par_en_q;
    par_bit_d    = par_bit_q;
    bit_cnt_d    = bit_cnt_q;
    stop_cnt_d   = stop_cnt_q;
    load_hold_s  = 1'b0;
    load_in_s    = 1'b0;
    shifted_s    = {DATA_BITS{1'b0}};
    tx_d         = UART_IDLE_LEVEL;

    case (state_q)
      IDLE: begin
        if (hold_valid_q) begin
          state_d     = START;
          load_hold_s = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (tick_s) begin
          state_d   = DATA;
          bit_cnt_d = {BIT_W{1'b0}};
        end else begin
          state_d = START;
        end
      end
      DATA: begin
        if (tick_s) begin
          if (bit_cnt_q == BIT_W'(DATA_BITS - 1)) begin
            state_d    = par_en_q ? PARITY : STOP;
            stop_cnt_d = 1'b0;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else begin
          state_d = DATA;
        end
      end
      PARITY: begin
        if (tick_s) begin
          state_d    = STOP;
          stop_cnt_d = 1'b0;
        end else begin
          state_d = PARITY;
        end
      end
      STOP: begin
        if (tick_s && last_stop_s) begin
          // A byte arriving on the final stop clock is sent straight from the input.
          if (hold_valid_q) begin
            state_d     = START;
            load_hold_s = 1'b1;
          end else if (accept_s) begin
            state_d   = START;
            load_in_s = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else if (tick_s) begin
          stop_cnt_d = ~stop_cnt_q;
        end else begin
          state_d = STOP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (load_hold_s) begin
      shift_d   = hold_data_q;
      par_en_d  = parity_on(hold_par_q);
      par_bit_d = parity_bit(hold_data_q, hold_par_q);
    end else if (load_in_s) begin
      shift_d   = in_data;
      par_en_d  = parity_on(uart_parity_e'(parity_mode));
      par_bit_d = parity_bit(in_data, uart_parity_e'(parity_mode));
    end else begin
      shift_d = shift_q;
    end

    if (accept_s && !load_in_s) begin
      hold_data_d  = in_data;
      hold_par_d   = uart_parity_e'(parity_mode);
      hold_valid_d = 1'b1;
    end else if (load_hold_s) begin
      hold_valid_d = 1'b0;
    end else begin
      hold_valid_d = hold_valid_q;
    end

    shifted_s = shift_d >> bit_cnt_d;
    case (state_d)
      IDLE:    tx_d = UART_IDLE_LEVEL;
      START:   tx_d = 1'b0;
      DATA:    tx_d = shifted_s[0];
      PARITY:  tx_d = par_bit_d;
      STOP:    tx_d = 1'b1;
      default: tx_d = UART_IDLE_LEVEL;
    endcase

    busy_d = (state_d != IDLE) | hold_valid_d;
    // Raised one clock early so the registered pulse covers the final stop clock.
    done_d = (state_q == STOP) && last_stop_s && (cnt_s == CNT_W'(CLKS_PER_BIT - 2));
  end

  // State, datapath and output registers; reset forces the line idle at once.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= IDLE;
      hold_data_q  <= {DATA_BITS{1'b0}};
      hold_par_q   <= PAR_NONE;
      hold_valid_q <= 1'b0;
      shift_q      <= {DATA_BITS{1'b0}};
      par_en_q     <= 1'b0;
      par_bit_q    <= 1'b0;
      bit_cnt_q    <= {BIT_W{1'b0}};
      stop_cnt_q   <= 1'b0;
      tx_q         <= UART_IDLE_LEVEL;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_data_q  <= hold_data_d;
      hold_par_q   <= hold_par_d;
      hold_valid_q <= hold_valid_d;
      shift_q      <= shift_d;
      par_en_q     <= par_en_d;
      par_bit_q    <= par_bit_d;
      bit_cnt_q    <= bit_cnt_d;
      stop_cnt_q   <= stop_cnt_d;
      tx_q         <= tx_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign tx         = tx_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: two instances (8N1-style and 5-bit/2-stop),
// line checked every clock against hand-computed frame bit patterns.
module tb_uart_tx_frame;

  logic       clk;
  logic       n_rst;

  logic       in_valid_a, in_ready_a, tx_a, busy_a, frame_done_a;
  logic [7:0] in_data_a;
  logic [1:0] parity_mode_a;

  logic       in_valid_b, in_ready_b, tx_b, busy_b, frame_done_b;
  logic [4:0] in_data_b;
  logic [1:0] parity_mode_b;

  logic sel_b;
  logic tx_m, busy_m, in_ready_m, frame_done_m;

  int checks = 0;
  int errors = 0;

  assign tx_m         = sel_b ? tx_b : tx_a;
  assign busy_m       = sel_b ? busy_b : busy_a;
  assign in_ready_m   = sel_b ? in_ready_b : in_ready_a;
  assign frame_done_m = sel_b ? frame_done_b : frame_done_a;

  uart_tx_frame #(.CLKS_PER_BIT(4), .DATA_BITS(8), .STOP_BITS(1)) u_dut_a (
    .clk        (clk),
    .n_rst      (n_rst),
    .in_valid   (in_valid_a),
    .in_ready   (in_ready_a),
    .in_data    (in_data_a),
    .parity_mode(parity_mode_a),
    .tx         (tx_a),
    .busy       (busy_a),
    .frame_done (frame_done_a)
  );

  uart_tx_frame #(.CLKS_PER_BIT(4), .DATA_BITS(5), .STOP_BITS(2)) u_dut_b (
    .clk        (clk),
    .n_rst      (n_rst),
    .in_valid   (in_valid_b),
    .in_ready   (in_ready_b),
    .in_data    (in_data_b),
    .parity_mode(parity_mode_b),
    .tx         (tx_b),
    .busy       (busy_b),
    .frame_done (frame_done_b)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Offer one byte on the selected instance; returns at the negedge after the accepting edge.
  task automatic send(input logic [7:0] d, input logic [1:0] m);
    int g = 0;
    if (sel_b) begin
      in_data_b = d[4:0]; parity_mode_b = m; in_valid_b = 1'b1;
    end else begin
      in_data_a = d; parity_mode_a = m; in_valid_a = 1'b1;
    end
    while (in_ready_m !== 1'b1 && g < 200) begin
      @(negedge clk);
      g++;
    end
    chk("send_ready", 32'(g < 200), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid_a = 1'b0;
    in_valid_b = 1'b0;
  endtask

  // Wait for the start bit, then check tx and frame_done on every clock of the frame.
  // bits holds the line values in transmit order, first bit in bit 0.
  task automatic capture(input string tag, input logic [15:0] bits, input int nbits, input int exp_wait);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (tx_m !== 1'b0 && n < 200);
    chk({tag, "_wait"}, 32'(n), 32'(exp_wait));
    for (int i = 0; i < nbits; i++) begin
      for (int c = 0; c < 4; c++) begin
        if (!(i == 0 && c == 0)) @(negedge clk);
        chk($sformatf("%s_tx_b%0d_c%0d", tag, i, c), 32'(tx_m), 32'(bits[i]));
        chk($sformatf("%s_done_b%0d_c%0d", tag, i, c), 32'(frame_done_m),
            32'((i == nbits - 1) && (c == 3)));
      end
    end
  endtask

  initial begin
    logic [7:0] feed [3];
    int g;
    feed[0] = 8'h01; feed[1] = 8'h02; feed[2] = 8'h03;
    sel_b = 1'b0;
    in_valid_a = 1'b0; in_data_a = 8'h00; parity_mode_a = 2'd0;
    in_valid_b = 1'b0; in_data_b = 5'h00; parity_mode_b = 2'd0;
    n_rst = 1'b0;
    repeat (3) @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);

    // Reset state on both instances.
    chk("rst_tx_a", 32'(tx_a), 32'd1);
    chk("rst_busy_a", 32'(busy_a), 32'd0);
    chk("rst_ready_a", 32'(in_ready_a), 32'd1);
    chk("rst_done_a", 32'(frame_done_a), 32'd0);
    chk("rst_tx_b", 32'(tx_b), 32'd1);
    chk("rst_ready_b", 32'(in_ready_b), 32'd1);

    // 0x55 no parity: 0,1,0,1,0,1,0,1,0,1.
    send(8'h55, 2'd0);
    chk("t1_tx_hs", 32'(tx_a), 32'd1);
    chk("t1_busy_hs", 32'(busy_a), 32'd1);
    chk("t1_ready_hs", 32'(in_ready_a), 32'd0);
    capture("t1", 16'h02AA, 10, 1);
    @(negedge clk);
    chk("t1_busy_end", 32'(busy_a), 32'd0);
    chk("t1_tx_end", 32'(tx_a), 32'd1);
    chk("t1_done_end", 32'(frame_done_a), 32'd0);

    // 0xA3 even parity (bit 0), then odd parity (bit 1).
    send(8'hA3, 2'd1);
    capture("t2e", 16'h0546, 11, 1);
    @(negedge clk);
    send(8'hA3, 2'd2);
    capture("t2o", 16'h0746, 11, 1);
    @(negedge clk);
    chk("t2_busy_end", 32'(busy_a), 32'd0);

    // Three bytes with in_valid held: contiguous frames.
    fork
      begin
        for (int k = 0; k < 3; k++) begin
          in_data_a = feed[k];
          parity_mode_a = 2'd0;
          in_valid_a = 1'b1;
          g = 0;
          while (in_ready_a !== 1'b1 && g < 500) begin
            @(negedge clk);
            g++;
          end
          chk($sformatf("t3_feed%0d", k), 32'(g < 500), 32'd1);
          @(posedge clk);
          @(negedge clk);
          if (k == 1) chk("t3_ready_drop", 32'(in_ready_a), 32'd0);
        end
        in_valid_a = 1'b0;
      end
      begin
        capture("t3f1", 16'h0202, 10, 2);
        capture("t3f2", 16'h0204, 10, 1);
        capture("t3f3", 16'h0206, 10, 1);
      end
    join
    @(negedge clk);
    chk("t3_busy_end", 32'(busy_a), 32'd0);

    // 5 data bits, 2 stops, 0x1F odd parity: 0,11111,0,1,1.
    sel_b = 1'b1;
    send(8'h1F, 2'd2);
    capture("t4", 16'h01BE, 9, 1);
    @(negedge clk);
    chk("t4_busy_end", 32'(busy_b), 32'd0);
    chk("t4_tx_end", 32'(tx_b), 32'd1);
    sel_b = 1'b0;

    // Asynchronous reset mid-DATA, then a clean 0x00 frame.
    send(8'h00, 2'd0);
    repeat (20) @(negedge clk);
    chk("t5_pre_tx", 32'(tx_a), 32'd0);
    chk("t5_pre_busy", 32'(busy_a), 32'd1);
    #2;
    n_rst = 1'b0;
    #1;
    chk("t5_rst_tx", 32'(tx_a), 32'd1);
    chk("t5_rst_busy", 32'(busy_a), 32'd0);
    chk("t5_rst_ready", 32'(in_ready_a), 32'd1);
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    chk("t5_post_tx", 32'(tx_a), 32'd1);
    chk("t5_post_busy", 32'(busy_a), 32'd0);
    send(8'h00, 2'd0);
    capture("t5", 16'h0200, 10, 1);
    @(negedge clk);

    // Inputs change after the handshake: 0xC4 even parity must go out unchanged.
    send(8'hC4, 2'd1);
    in_data_a = 8'h3B;
    parity_mode_a = 2'd2;
    capture("t6", 16'h0788, 11, 1);
    @(negedge clk);
    chk("t6_busy_end", 32'(busy_a), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
